// File: rtl/mvm_arbiter.sv
// mvm_arbiter: round-robin sharing of one 4x4 matrix-vector multiplier among NUM_REQ requesters.
// Optional WAIT-state watchdog is compiled in when MVM_ARB_TIMEOUT_EN is defined.
module mvm_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                                    clk_in,
    input  logic                                    rst_in,
    input  logic [NUM_REQ-1:0]                      req_in,
    input  logic [NUM_REQ-1:0][3:0][3:0][WIDTH-1:0] m_in,
    input  logic [NUM_REQ-1:0][3:0][WIDTH-1:0]      v_in,
    output logic [NUM_REQ-1:0]                      ack_out,
    output logic [NUM_REQ-1:0]                      res_valid_out,
    output logic [3:0][WIDTH-1:0]                   res_out,
    output logic                                    busy_out,
    output logic                                    err_out,
    output logic                                    mvm_start_out,
    output logic [3:0][3:0][WIDTH-1:0]              mvm_m_out,
    output logic [3:0][WIDTH-1:0]                   mvm_v_out,
    input  logic                                    mvm_done_in,
    input  logic [3:0][WIDTH-1:0]                   mvm_v_in
);
    localparam int PTR_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("mvm_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t                   state_q, state_d;
    logic [PTR_W-1:0]         grant_q, grant_d;
    logic [PTR_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]         winner;
    logic [NUM_REQ-1:0]       ack_q, ack_d;
    logic [NUM_REQ-1:0]       res_valid_q, res_valid_d;
    logic [3:0][WIDTH-1:0]    res_q, res_d;
    logic                     busy_q, busy_d;
    logic                     start_q, start_d;
    logic [3:0][3:0][WIDTH-1:0] mvm_m_q, mvm_m_d;
    logic [3:0][WIDTH-1:0]    mvm_v_q, mvm_v_d;

`ifdef MVM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`endif

    // Scan rr_ptr+1, rr_ptr+2, ... ; descending loop lets the nearest requester win.
    always_comb begin
        logic [PTR_W-1:0] idx;
        winner = rr_ptr_q;
        idx    = rr_ptr_q;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (req_in[idx]) winner = idx;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        ack_d       = '0;
        res_valid_d = '0;
        start_d     = 1'b0;
        res_d       = res_q;
        mvm_m_d     = mvm_m_q;
        mvm_v_d     = mvm_v_q;
`ifdef MVM_ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_d       = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (|req_in) begin
                    grant_d         = winner;
                    mvm_m_d         = m_in[winner];
                    mvm_v_d         = v_in[winner];
                    ack_d[winner]   = 1'b1;
                    start_d         = 1'b1;
                    state_d         = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef MVM_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT: begin
                if (mvm_done_in) begin
                    res_d                = mvm_v_in;
                    res_valid_d[grant_q] = 1'b1;
                    rr_ptr_d             = grant_q;
                    state_d              = IDLE;
                end
`ifdef MVM_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    // Abort: the requester is skipped for fairness, no result is emitted.
                    err_d    = 1'b1;
                    rr_ptr_d = grant_q;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= PTR_W'(NUM_REQ - 1);
            ack_q       <= '0;
            res_valid_q <= '0;
            res_q       <= '0;
            busy_q      <= 1'b0;
            start_q     <= 1'b0;
            mvm_m_q     <= '0;
            mvm_v_q     <= '0;
`ifdef MVM_ARB_TIMEOUT_EN
            cnt_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            ack_q       <= ack_d;
            res_valid_q <= res_valid_d;
            res_q       <= res_d;
            busy_q      <= busy_d;
            start_q     <= start_d;
            mvm_m_q     <= mvm_m_d;
            mvm_v_q     <= mvm_v_d;
`ifdef MVM_ARB_TIMEOUT_EN
            cnt_q       <= cnt_d;
            err_q       <= err_d;
`endif
        end
    end

    assign ack_out       = ack_q;
    assign res_valid_out = res_valid_q;
    assign res_out       = res_q;
    assign busy_out      = busy_q;
    assign mvm_start_out = start_q;
    assign mvm_m_out     = mvm_m_q;
    assign mvm_v_out     = mvm_v_q;
`ifdef MVM_ARB_TIMEOUT_EN
    assign err_out       = err_q;
`else
    assign err_out       = 1'b0;
`endif

endmodule

// File: tb/tb_mvm_arbiter.sv
// Bench for mvm_arbiter: a 6-cycle multiplier model plus a scoreboard of expected results.
`timescale 1ns/1ps
module tb_mvm_arbiter;
    localparam int NR = 4;
    localparam int W  = 32;

    typedef logic [3:0][3:0][W-1:0] mat_t;
    typedef logic [3:0][W-1:0]      vec_t;
    typedef struct {
        int   idx;
        vec_t res;
    } exp_t;

    logic                           clk = 1'b0;
    logic                           rst = 1'b0;
    logic [NR-1:0]                  req = '0;
    logic [NR-1:0][3:0][3:0][W-1:0] m   = '0;
    logic [NR-1:0][3:0][W-1:0]      v   = '0;
    logic [NR-1:0]                  ack, res_valid;
    vec_t                           res;
    logic                           busy, err, mvm_start;
    mat_t                           mvm_m;
    vec_t                           mvm_v;
    logic                           mvm_done;
    vec_t                           mvm_res;
    logic                           model_done;
    logic                           stray_done = 1'b0;
    logic                           hold_done_low = 1'b0;
    int                             model_cnt;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t sb[$];
    vec_t last_res = '0;

    mvm_arbiter #(.NUM_REQ(NR), .WIDTH(W), .TIMEOUT_CYCLES(64)) dut (
        .clk_in(clk), .rst_in(rst), .req_in(req), .m_in(m), .v_in(v),
        .ack_out(ack), .res_valid_out(res_valid), .res_out(res),
        .busy_out(busy), .err_out(err), .mvm_start_out(mvm_start),
        .mvm_m_out(mvm_m), .mvm_v_out(mvm_v), .mvm_done_in(mvm_done),
        .mvm_v_in(mvm_res)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic vec_t mvm_mul(mat_t a, vec_t b);
        vec_t   r;
        longint acc;
        for (int i = 0; i < 4; i++) begin
            acc = 0;
            for (int j = 0; j < 4; j++)
                acc += longint'($signed(a[i][j])) * longint'($signed(b[j]));
            r[i] = W'(acc >>> 16);
        end
        return r;
    endfunction

    // Multiplier model: done 6 cycles after start, result taken from operands at done time.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_cnt  <= 0;
            model_done <= 1'b0;
            mvm_res    <= '0;
        end else begin
            model_done <= (model_cnt == 1);
            if (model_cnt == 1) mvm_res <= mvm_mul(mvm_m, mvm_v);
            if (model_cnt != 0) model_cnt <= model_cnt - 1;
            if (mvm_start) model_cnt <= 5;
        end
    end
    assign mvm_done = (model_done & ~hold_done_low) | stray_done;

    task automatic apply_reset();
        @(posedge clk); #1;
        rst = 1'b1; req = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic set_ops(input int i);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++)
                m[i][r][c] = (r == c) ? W'((i + 1) << 16) : W'((r + c + i) << 14);
            v[i][r] = W'(r + 1 + 3 * i);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        total++; if (ack !== '0 || res_valid !== '0 || mvm_start !== 1'b0) begin
            bad++; $display("FAIL reset_ctrl: got ack=%b rv=%b st=%b want 0", ack, res_valid, mvm_start); end
        total++; if (busy !== 1'b0 || err !== 1'b0 || res !== '0) begin
            bad++; $display("FAIL reset_state: got busy=%b err=%b res=%h want 0", busy, err, res); end
        set_ops(1);
        @(posedge clk); #1 req = 4'b0010;
        @(negedge clk); @(negedge clk); req = '0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        total++; if (busy !== 1'b0 || mvm_m !== '0 || mvm_v !== '0 || ack !== '0 || mvm_start !== 1'b0) begin
            bad++; $display("FAIL reset_midwait: got busy=%b mvm_m=%h mvm_v=%h want 0", busy, mvm_m, mvm_v); end
        @(posedge clk); #1 rst = 1'b0;
        begin
            logic seen = 1'b0;
            for (int k = 0; k < 12; k++) begin
                @(negedge clk);
                if (res_valid !== '0 || busy !== 1'b0) seen = 1'b1;
            end
            total++; if (seen !== 1'b0) begin
                bad++; $display("FAIL reset_no_result: got activity=%b want 0", seen); end
        end
    endtask

    task automatic test_single();
        exp_t e;
        int   n;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) m[0][r][c] = (r == c) ? 32'h0001_0000 : 32'h0;
            v[0][r] = W'(r + 1);
        end
        e.idx = 0;
        e.res = {32'd4, 32'd3, 32'd2, 32'd1};
        @(posedge clk); #1 req = 4'b0001;
        sb.push_back(e);
        @(negedge clk);
        @(negedge clk);
        total++; if (ack !== 4'b0001 || mvm_start !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL single_ack: got ack=%b st=%b busy=%b want 0001 1 1", ack, mvm_start, busy); end
        req = '0;
        n = 1;
        do begin @(negedge clk); n++; end while (res_valid === '0 && n < 20);
        total++; if (n !== 8 || res_valid !== 4'b0001) begin
            bad++; $display("FAIL single_latency: got cycle=%0d rv=%b want 8 0001", n, res_valid); end
        e = sb.pop_front();
        total++; if (res !== e.res) begin
            bad++; $display("FAIL single_result: got %h want %h", res, e.res); end
        last_res = e.res;
        @(negedge clk);
        total++; if (res_valid !== '0 || err !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL single_pulse: got rv=%b err=%b busy=%b want 0", res_valid, err, busy); end
    endtask

    task automatic test_round_robin();
        int   order[5] = '{0, 1, 2, 3, 0};
        int   n;
        int   last_cyc;
        exp_t e;
        apply_reset();
        for (int i = 0; i < NR; i++) set_ops(i);
        @(posedge clk); #1 req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            e.idx = order[t];
            e.res = mvm_mul(m[order[t]], v[order[t]]);
            sb.push_back(e);
        end
        last_cyc = 0;
        for (int t = 0; t < 5; t++) begin
            n = 0;
            do begin @(negedge clk); n++; end while (ack === '0 && n < 40);
            total++; if (ack !== NR'(1 << order[t])) begin
                bad++; $display("FAIL rr_grant%0d: got %b want %b", t, ack, NR'(1 << order[t])); end
            if (t == 4) req = '0;
            n = 0;
            do begin @(negedge clk); n++; end while (res_valid === '0 && n < 40);
            e = sb.pop_front();
            total++; if (res_valid !== NR'(1 << e.idx) || res !== e.res) begin
                bad++; $display("FAIL rr_result%0d: got rv=%b res=%h want %b %h", t, res_valid, res, NR'(1 << e.idx), e.res); end
            if (t > 0) begin
                total++; if (cyc - last_cyc !== 8) begin
                    bad++; $display("FAIL rr_spacing%0d: got %0d want 8", t, cyc - last_cyc); end
            end
            last_cyc = cyc;
            last_res = e.res;
        end
    endtask

    task automatic test_drop();
        exp_t e;
        int   n;
        logic seen = 1'b0;
        e.idx = 0;
        e.res = mvm_mul(m[0], v[0]);
        @(posedge clk); #1 req = 4'b0001;
        sb.push_back(e);
        n = 0;
        do begin @(negedge clk); n++; end while (ack === '0 && n < 20);
        total++; if (ack !== 4'b0001) begin
            bad++; $display("FAIL drop_grant: got %b want 0001", ack); end
        req = '0;
        @(negedge clk); @(negedge clk);
        req = 4'b0100;
        @(negedge clk);
        req = '0;
        n = 0;
        do begin @(negedge clk); n++; if (ack[2] === 1'b1) seen = 1'b1; end
        while (res_valid === '0 && n < 20);
        e = sb.pop_front();
        total++; if (res_valid !== 4'b0001 || res !== e.res) begin
            bad++; $display("FAIL drop_result: got rv=%b res=%h want 0001 %h", res_valid, res, e.res); end
        last_res = e.res;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (ack !== '0 || res_valid !== '0) seen = 1'b1;
        end
        total++; if (seen !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL drop_ignored: got activity=%b busy=%b want 0 0", seen, busy); end
    endtask

    task automatic test_stray_done();
        logic seen = 1'b0;
        @(negedge clk); stray_done = 1'b1;
        @(negedge clk); stray_done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (res_valid !== '0 || busy !== 1'b0) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin
            bad++; $display("FAIL stray_valid: got activity=%b want 0", seen); end
        total++; if (res !== last_res) begin
            bad++; $display("FAIL stray_res: got %h want %h", res, last_res); end
    endtask

`ifdef MVM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        exp_t e;
        int   n;
        logic seen = 1'b0;
        set_ops(1);
        hold_done_low = 1'b1;
        @(posedge clk); #1 req = 4'b0010;
        @(negedge clk); @(negedge clk);
        total++; if (ack !== 4'b0010) begin
            bad++; $display("FAIL to_grant: got %b want 0010", ack); end
        req = '0;
        n = 1;
        do begin @(negedge clk); n++; if (res_valid !== '0) seen = 1'b1; end
        while (err === 1'b0 && n < 120);
        total++; if (n !== 66 || err !== 1'b1 || seen !== 1'b0) begin
            bad++; $display("FAIL to_err: got cycle=%0d err=%b rv_seen=%b want 66 1 0", n, err, seen); end
        @(negedge clk);
        total++; if (err !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL to_after: got err=%b busy=%b want 0 0", err, busy); end
        hold_done_low = 1'b0;
        e.idx = 1;
        e.res = mvm_mul(m[1], v[1]);
        @(posedge clk); #1 req = 4'b0010;
        sb.push_back(e);
        n = 0;
        do begin @(negedge clk); n++; end while (ack === '0 && n < 20);
        req = '0;
        n = 0;
        do begin @(negedge clk); n++; end while (res_valid === '0 && n < 20);
        e = sb.pop_front();
        total++; if (res_valid !== 4'b0010 || res !== e.res) begin
            bad++; $display("FAIL to_recover: got rv=%b res=%h want 0010 %h", res_valid, res, e.res); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_drop();
        test_stray_done();
`ifdef MVM_ARB_TIMEOUT_EN
        test_timeout();
`endif
        total++; if (sb.size() !== 0) begin
            bad++; $display("FAIL scoreboard_empty: got %0d left want 0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
